// File: rtl/tc_clk_gate_ctrl.sv
// Idle-driven clock-gate enable controller. Runs on the free-running clock.
// It gates after a run of idle cycles, reopens on activity or a wake request, and acks the request once the clock has settled.
module tc_clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              test_en_i,
  input  logic              force_on_i,
  input  logic              busy_i,
  input  logic              wake_req_i,
  output logic              wake_ack_o,
  output logic              clk_en_o,
  output logic              gated_o,
  output logic [STAT_W-1:0] gated_cnt_o
);

  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? WW'(WAKE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  state_t            state_reg;
  logic              en_reg;
  logic              ack_done_reg;
  logic              wake_ack_reg;
  logic [IW-1:0]     idle_cnt_reg;
  logic [WW-1:0]     wake_cnt_reg;
  logic [STAT_W-1:0] gated_cnt_reg;
  logic              idle;

  assign idle = !busy_i && !wake_req_i && !force_on_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_RUN;
      en_reg        <= 1'b1;
      ack_done_reg  <= 1'b0;
      wake_ack_reg  <= 1'b0;
      idle_cnt_reg  <= '0;
      wake_cnt_reg  <= '0;
      gated_cnt_reg <= '0;
    end else begin
      wake_ack_reg <= 1'b0;
      if (!wake_req_i) begin
        ack_done_reg <= 1'b0;
      end
      unique case (state_reg)
        ST_RUN: begin
          // Ack only once the clock is fully running; one pulse per request.
          if (wake_req_i && !ack_done_reg) begin
            wake_ack_reg <= 1'b1;
            ack_done_reg <= 1'b1;
          end
          if (!idle) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg == IDLE_LAST) begin
            state_reg    <= ST_GATED;
            en_reg       <= 1'b0;
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        ST_GATED: begin
          gated_cnt_reg <= gated_cnt_reg + 1'b1;
          if (!idle) begin
            en_reg <= 1'b1;
            if (WAKE_CYCLES > 0) begin
              state_reg    <= ST_WAKE;
              wake_cnt_reg <= WAKE_LOAD;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_WAKE: begin
          if (wake_cnt_reg == '0) begin
            state_reg <= ST_RUN;
          end else begin
            wake_cnt_reg <= wake_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= ST_RUN;
          en_reg    <= 1'b1;
        end
      endcase
    end
  end

  // Test mode only forces the enable; the controller keeps running underneath.
  assign clk_en_o    = en_reg | test_en_i;
  assign gated_o     = (state_reg == ST_GATED);
  assign wake_ack_o  = wake_ack_reg;
  assign gated_cnt_o = gated_cnt_reg;

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// Bench for tc_clk_gate_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_tc_clk_gate_ctrl;
  localparam int IDLE = 16;
  localparam int WAKE = 2;
  localparam int SW   = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          test_en_i = 1'b0;
  logic          force_on_i = 1'b0;
  logic          busy_i = 1'b0;
  logic          wake_req_i = 1'b0;
  logic          wake_ack_o;
  logic          clk_en_o;
  logic          gated_o;
  logic [SW-1:0] gated_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  tc_clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .STAT_W(SW)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .test_en_i(test_en_i),
    .force_on_i(force_on_i),
    .busy_i(busy_i),
    .wake_req_i(wake_req_i),
    .wake_ack_o(wake_ack_o),
    .clk_en_o(clk_en_o),
    .gated_o(gated_o),
    .gated_cnt_o(gated_cnt_o)
  );

  // Model: sleeping flag, remaining settle cycles (-1 = fully running),
  // length of the current quiet run, and whether the live request was served.
  bit m_sleeping;
  int m_wake_left;
  int m_quiet_run;
  bit m_served;
  bit m_ack;
  int m_total;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_sleeping  <= 1'b0;
      m_wake_left <= -1;
      m_quiet_run <= 0;
      m_served    <= 1'b0;
      m_ack       <= 1'b0;
      m_total     <= 0;
    end else begin : model_step
      automatic bit quiet = !busy_i && !wake_req_i && !force_on_i;
      automatic bit sl    = m_sleeping;
      automatic int wl    = m_wake_left;
      automatic int run   = m_quiet_run;
      automatic bit srv   = m_served;
      automatic bit ack   = 1'b0;
      automatic int tot   = m_total;
      if (sl) begin
        tot = (tot + 1) % (1 << SW);
        if (!quiet) begin
          sl = 1'b0;
          wl = WAKE - 1;
        end
      end else if (wl >= 0) begin
        wl = wl - 1;
      end else begin
        if (wake_req_i && !srv) begin
          ack = 1'b1;
          srv = 1'b1;
        end
        if (quiet) begin
          run = run + 1;
          if (run == IDLE) begin
            sl  = 1'b1;
            run = 0;
          end
        end else begin
          run = 0;
        end
      end
      if (!wake_req_i) srv = 1'b0;
      m_sleeping  <= sl;
      m_wake_left <= wl;
      m_quiet_run <= run;
      m_served    <= srv;
      m_ack       <= ack;
      m_total     <= tot;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    check("model_clk_en", 32'(clk_en_o), 32'(!m_sleeping || test_en_i));
    check("model_gated", 32'(gated_o), 32'(m_sleeping));
    check("model_ack", 32'(wake_ack_o), 32'(m_ack));
    check("model_cnt", 32'(gated_cnt_o), 32'(m_total));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  initial begin
    step(2);
    check("rst_clk_en", 32'(clk_en_o), 32'd1);
    check("rst_gated", 32'(gated_o), 32'd0);
    check("rst_ack", 32'(wake_ack_o), 32'd0);
    check("rst_cnt", 32'(gated_cnt_o), 32'd0);
    rst_ni = 1'b1;

    // Gate after the 16th quiet edge
    for (int k = 1; k <= IDLE; k++) begin
      step(1);
      if (k < IDLE) check("t1_en_before", 32'(clk_en_o), 32'd1);
      else begin
        check("t1_en_after", 32'(clk_en_o), 32'd0);
        check("t1_gated", 32'(gated_o), 32'd1);
      end
    end

    // 100 cycles in GATED, busy on the last one
    step(99);
    busy_i = 1'b1;
    step(1);
    busy_i = 1'b0;
    check("t4_cnt", 32'(gated_cnt_o), 32'd100);
    check("t4_en", 32'(clk_en_o), 32'd1);
    check("t4_gated", 32'(gated_o), 32'd0);

    // Wake handshake from GATED
    step(WAKE + IDLE);
    check("t3_gated_pre", 32'(gated_o), 32'd1);
    wake_req_i = 1'b1;
    step(1);
    check("t3_en", 32'(clk_en_o), 32'd1);
    check("t3_ack_e0", 32'(wake_ack_o), 32'd0);
    step(1);
    check("t3_ack_e1", 32'(wake_ack_o), 32'd0);
    step(1);
    check("t3_ack_e2", 32'(wake_ack_o), 32'd0);
    step(1);
    check("t3_ack_e3", 32'(wake_ack_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("t3_no_second_ack", 32'(wake_ack_o), 32'd0);
    end
    wake_req_i = 1'b0;

    // test_en while GATED
    step(IDLE);
    test_en_i = 1'b1;
    step(5);
    check("t5_en", 32'(clk_en_o), 32'd1);
    check("t5_gated", 32'(gated_o), 32'd1);
    check("t5_cnt", 32'(gated_cnt_o), 32'd106);
    test_en_i = 1'b0;
    #1;
    check("t5_en_off", 32'(clk_en_o), 32'd0);

    // Reset mid-WAKE
    step(1);
    busy_i = 1'b1;
    step(1);
    busy_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("t6_en", 32'(clk_en_o), 32'd1);
    check("t6_gated", 32'(gated_o), 32'd0);
    check("t6_ack", 32'(wake_ack_o), 32'd0);
    check("t6_cnt", 32'(gated_cnt_o), 32'd0);
    step(2);
    rst_ni = 1'b1;

    // Periodic busy never lets the run reach the limit
    for (int k = 0; k < 100; k++) begin
      busy_i = (k % 10 == 9);
      step(1);
      check("t2_en", 32'(clk_en_o), 32'd1);
    end
    busy_i = 1'b0;

    // Statistics counter wraps
    step(IDLE + (1 << SW) + 4);
    check("wrap_cnt", 32'(gated_cnt_o), 32'd4);
    check("wrap_gated", 32'(gated_o), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      busy_i     = ($urandom_range(0, 19) == 0);
      force_on_i = ($urandom_range(0, 99) == 0);
      test_en_i  = ($urandom_range(0, 49) == 0);
      if (!wake_req_i) wake_req_i = ($urandom_range(0, 39) == 0);
      else if ($urandom_range(0, 7) == 0) wake_req_i = 1'b0;
      rst_ni = ($urandom_range(0, 499) != 0);
      step(1);
    end
    rst_ni = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
